maxpool2x2_stream: RTL and testbench

//  Streaming 2x2 max-pool, stride 2, on a raster-order feature-map stream.

---
 rtl/maxpool2x2_stream.sv | 121 ++++++++++++
 tb/tb_maxpool2x2_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 max-pool with stride 2 on a raster-order pixel stream.
// Each pixel pair in a row is reduced to one horizontal max. On even rows that max is
// stored in a half-width row buffer. On odd rows it is merged with the stored value,
// and the merged result is emitted one cycle after the window's bottom-right pixel.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool2x2_stream #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic [WIDTH-1:0] din,
  output logic             dout_vld,
  output logic [WIDTH-1:0] dout,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int HALF  = IMG_W / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             frame_done_q, frame_done_d;

  logic [WIDTH-1:0] rowbuf_q [HALF];
  logic             buf_we;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] buf_rd;
  logic [WIDTH-1:0] hmax;
  logic [WIDTH-1:0] pooled;
  logic [WIDTH-1:0] pooled_out;
  logic             last_col;
  logic             last_row;

  // Signed maximum; on a tie either operand is the same value.
  function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  assign idx      = IDX_W'(col_q >> 1);
  assign buf_rd   = rowbuf_q[idx];
  assign hmax     = smax(h_q, din);
  assign pooled   = smax(buf_rd, hmax);
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));

`ifdef MAXPOOL_RELU_EN
  assign pooled_out = pooled[WIDTH-1] ? '0 : pooled;
`else
  assign pooled_out = pooled;
`endif

  // Next-state logic: pair capture, row-buffer write, output formation, raster counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    col_d        = col_q;
    row_d        = row_q;
    h_d          = h_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;
    if (din_vld) begin
      if (!col_q[0]) begin
        h_d = din;
      end else if (!row_q[0]) begin
        buf_we = 1'b1;
      end else begin
        dout_d       = pooled_out;
        dout_vld_d   = 1'b1;
        frame_done_d = last_row && last_col;
      end
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_q          <= h_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffer: horizontal maxima of the even row, read back on the odd row.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the memory; every entry is written on an even row before it is read.
    if (buf_we) begin
      rowbuf_q[idx] <= hmax;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Testbench for maxpool2x2_stream on a 4x4 frame. The driver pushes hand-computed
// expected results into a scoreboard when a window's last pixel is accepted. A monitor
// samples on the falling edge, pops entries on each strobe, and checks value,
// frame_done and the one-cycle latency.
module tb_maxpool2x2_stream;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_vld;
  logic [7:0] din;
  logic       dout_vld;
  logic [7:0] dout;
  logic       frame_done;

  maxpool2x2_stream #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_vld    (din_vld),
    .din        (din),
    .dout_vld   (dout_vld),
    .dout       (dout),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit fd;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] px [W*H];
  int         ex [4];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Send the first n pixels of px. When a pixel completes a window, push the next entry of ex.
  task automatic send(input int n, input int max_gap);
    int   k;
    int   gap;
    exp_t e;
    k = 0;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) begin
        din_vld = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      din_vld = 1'b1;
      din     = px[i];
      @(posedge clk);
      #1;
      if (((i / W) % 2 == 1) && ((i % W) % 2 == 1)) begin
        e.data = ex[k];
        e.fd   = (i == W*H - 1);
        e.cyc  = cyc;
        sb.push_back(e);
        k++;
      end
    end
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    din_vld = 1'b0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < W*H; i++) px[i] = 8'(base + i);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < W*H; i++) px[i] = 8'(v);
  endtask

  // Monitor: checks the reset state, every strobe against the scoreboard, and idle cycles.
  initial begin
    bit     in_rst;
    int     last;
    exp_t   e;
    in_rst = 1'b0;
    last   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_rst = 1'b1;
      end else if (in_rst) begin
        check("reset_dout_vld", int'(dout_vld), 0);
        check("reset_dout", int'(dout), 0);
        check("reset_frame_done", int'(frame_done), 0);
        in_rst = 1'b0;
        last   = 0;
      end else if (dout_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", int'($signed(dout)), 9999);
        end else begin
          e = sb.pop_front();
          check("dout", int'($signed(dout)), e.data);
          check("frame_done", int'(frame_done), int'(e.fd));
          check("latency_cycle", cyc, e.cyc);
        end
        last = int'($signed(dout));
      end else begin
        check("frame_done_idle", int'(frame_done), 0);
        check("dout_hold", int'($signed(dout)), last);
      end
    end
  end

  // Stimulus.
  initial begin
    int vals [4];
    int r, c, w, p;
    rst     = 1'b0;
    din_vld = 1'b0;
    din     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1. Ramp 0..15 with no gaps.
    fill_ramp(0);
    ex = '{5, 7, 13, 15};
    send(W*H, 0);
    idle(3);

    // 2. Every pixel is -3.
    fill_const(-3);
`ifdef MAXPOOL_RELU_EN
    ex = '{0, 0, 0, 0};
`else
    ex = '{-3, -3, -3, -3};
`endif
    send(W*H, 0);
    idle(2);

    // 3. Window {-128,127,-1,0}, with 127 at a different position in each window.
    vals = '{-128, 127, -1, 0};
    for (int i = 0; i < W*H; i++) begin
      r = i / W;
      c = i % W;
      w = (r / 2) * 2 + c / 2;
      p = (r % 2) * 2 + c % 2;
      px[i] = 8'(vals[(p + w) % 4]);
    end
    ex = '{127, 127, 127, 127};
    send(W*H, 0);
    fill_const(-128);
`ifdef MAXPOOL_RELU_EN
    ex = '{0, 0, 0, 0};
`else
    ex = '{-128, -128, -128, -128};
`endif
    send(W*H, 0);
    idle(2);

    // 4. Ramp with random gaps of 0-5 idle cycles before each pixel.
    fill_ramp(0);
    ex = '{5, 7, 13, 15};
    send(W*H, 5);
    idle(3);

    // 5. Six pixels, then reset. Pixel 5 is (1,1), which completes window (0,0) before
    //    the reset. The rest of the partial frame is discarded, and the next frame
    //    starts at (0,0).
    fill_ramp(0);
    ex = '{5, 0, 0, 0};
    send(6, 0);
    do_reset();
    ex = '{5, 7, 13, 15};
    send(W*H, 0);
    idle(2);

    // 6. Two frames back-to-back.
    fill_ramp(0);
    ex = '{5, 7, 13, 15};
    send(W*H, 0);
    fill_ramp(100);
    ex = '{105, 107, 113, 115};
    send(W*H, 0);
    idle(4);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
